// File: rtl/mem_stage_mc_if.sv
// EX/MEM-side request bus and MEM-side result bus of the multi-cycle MEM stage.
interface mem_stage_mc_if #(
   parameter int unsigned NBITS = 32,
   parameter int unsigned TAM_M = 10
);
   logic             i_mips_clk_ctrl;
   logic [NBITS-1:0] i_EX_MEM_ALU;
   logic             i_EX_MEM_MemRead;
   logic             i_EX_MEM_MemWrite;
   logic [NBITS-1:0] i_EX_MEM_Reg2;
   logic [1:0]       i_EX_MEM_TamanoFiltro;
   logic             i_EX_MEM_Unsigned;
   logic [NBITS-1:0] i_mips_mem_debug;
   logic [NBITS-1:0] o_MEM_DataMemory;
   logic [NBITS-1:0] o_MEM_DataMemoryDebug;
   logic             o_MEM_Stall;
   logic             o_MEM_Done;
   logic             o_MEM_Misaligned;

   modport master (
      output i_mips_clk_ctrl, i_EX_MEM_ALU, i_EX_MEM_MemRead, i_EX_MEM_MemWrite,
             i_EX_MEM_Reg2, i_EX_MEM_TamanoFiltro, i_EX_MEM_Unsigned, i_mips_mem_debug,
      input  o_MEM_DataMemory, o_MEM_DataMemoryDebug, o_MEM_Stall, o_MEM_Done,
             o_MEM_Misaligned
   );

   modport slave (
      input  i_mips_clk_ctrl, i_EX_MEM_ALU, i_EX_MEM_MemRead, i_EX_MEM_MemWrite,
             i_EX_MEM_Reg2, i_EX_MEM_TamanoFiltro, i_EX_MEM_Unsigned, i_mips_mem_debug,
      output o_MEM_DataMemory, o_MEM_DataMemoryDebug, o_MEM_Stall, o_MEM_Done,
             o_MEM_Misaligned
   );
endinterface

// File: rtl/mem_stage_mc.sv
// Multi-cycle MIPS MEM stage: byte/half/word loads and stores with wait states,
// misalignment trap and a combinational debug read port.
module mem_stage_mc #(
   parameter int unsigned NBITS       = 32,
   parameter int unsigned TAM_M       = 10,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input logic           i_clk,
   input logic           i_reset,
   mem_stage_mc_if.slave bus
);
   localparam int unsigned BYTES = NBITS / 8;
   localparam int unsigned OFFB  = $clog2(BYTES);
   localparam int unsigned DEPTH = 2 ** TAM_M;
   localparam int unsigned CW    = 4;

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACCESS, ST_FAULT} state_t;

   state_t            state, state_nx;
   logic [CW-1:0]     cnt, cnt_nx;
   logic [NBITS-1:0]  mem [DEPTH];
   logic [NBITS-1:0]  data_q;

   logic              step, req, is_byte, is_half, misaligned;
   logic [OFFB-1:0]   offset;
   logic [TAM_M-1:0]  widx;
   logic [BYTES-1:0]  be;
   logic [NBITS-1:0]  wdata, rshift, ld_val;
   logic              unused_bits;

   assign step    = bus.i_mips_clk_ctrl;
   assign req     = bus.i_EX_MEM_MemRead | bus.i_EX_MEM_MemWrite;
   assign offset  = bus.i_EX_MEM_ALU[OFFB-1:0];
   assign widx    = bus.i_EX_MEM_ALU[OFFB+TAM_M-1:OFFB];
   assign is_byte = (bus.i_EX_MEM_TamanoFiltro == 2'b00);
   assign is_half = (bus.i_EX_MEM_TamanoFiltro == 2'b01);
   assign unused_bits = ^{bus.i_EX_MEM_ALU[NBITS-1:OFFB+TAM_M], bus.i_mips_mem_debug[NBITS-1:TAM_M]};

   always_comb begin
      misaligned = 1'b0;
      if (is_half)       misaligned = offset[0];
      else if (!is_byte) misaligned = (offset != '0);
   end

   // Little-endian lane placement; the enables mask off lanes not being stored.
   always_comb begin
      wdata = bus.i_EX_MEM_Reg2 << {offset, 3'b000};
      if (is_byte)      be = BYTES'(1) << offset;
      else if (is_half) be = BYTES'(3) << offset;
      else              be = '1;
   end

   always_comb begin
      rshift = mem[widx] >> {offset, 3'b000};
      if (is_byte)
         ld_val = bus.i_EX_MEM_Unsigned ? NBITS'(rshift[7:0])
                                        : {{(NBITS-8){rshift[7]}}, rshift[7:0]};
      else if (is_half)
         ld_val = bus.i_EX_MEM_Unsigned ? NBITS'(rshift[15:0])
                                        : {{(NBITS-16){rshift[15]}}, rshift[15:0]};
      else
         ld_val = rshift;
   end

   // Next-state; nothing moves while the step enable is low.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      if (step) begin
         case (state)
            ST_IDLE: if (req) begin
               if (misaligned)            state_nx = ST_FAULT;
               else if (WAIT_CYCLES == 0) state_nx = ST_ACCESS;
               else begin
                  state_nx = ST_WAIT;
                  cnt_nx   = CW'(WAIT_CYCLES);
               end
            end
            ST_WAIT: begin
               cnt_nx = cnt - CW'(1);
               if (cnt == CW'(1)) state_nx = ST_ACCESS;
            end
            default: state_nx = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         data_q <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         if (step && state == ST_ACCESS && !bus.i_EX_MEM_MemWrite) data_q <= ld_val;
         else if (step && state == ST_FAULT)                       data_q <= '0;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem[TAM_M'(i)] <= '0;
      end else if (step && state == ST_ACCESS && bus.i_EX_MEM_MemWrite) begin
         for (int unsigned b = 0; b < BYTES; b++)
            if (be[b]) mem[widx][8*b +: 8] <= wdata[8*b +: 8];
      end
   end

   assign bus.o_MEM_DataMemory      = data_q;
   assign bus.o_MEM_DataMemoryDebug = mem[bus.i_mips_mem_debug[TAM_M-1:0]];
   assign bus.o_MEM_Stall           = (state == ST_IDLE && req) || state == ST_WAIT;
   assign bus.o_MEM_Done            = (state == ST_ACCESS) || (state == ST_FAULT);
   assign bus.o_MEM_Misaligned      = (state == ST_FAULT);
endmodule
